// File: rtl/uart_alu_ctrl.sv
// Sequencer between the UART receiver, a combinational ALU and the UART transmitter.
// It collects operand A, operand B and an opcode, then transmits the ALU result and waits for transmit completion.
module uart_alu_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int NB_TOUT        = 20
) (
    input  logic               i_Clock,
    input  logic               i_reset_n,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_byte,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_byte,
    output logic               o_busy,
    output logic               o_error
);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_TX_START,
        S_TX_WAIT
    } state_t;

    localparam logic [NB_OP-1:0]   OP_ADD    = NB_OP'(8'h20);
    localparam logic [NB_OP-1:0]   OP_SUB    = NB_OP'(8'h22);
    localparam logic [NB_OP-1:0]   OP_AND    = NB_OP'(8'h24);
    localparam logic [NB_OP-1:0]   OP_OR     = NB_OP'(8'h25);
    localparam logic [NB_OP-1:0]   OP_XOR    = NB_OP'(8'h26);
    localparam logic [NB_OP-1:0]   OP_NOR    = NB_OP'(8'h27);
    localparam logic [NB_OP-1:0]   OP_SRA    = NB_OP'(8'h03);
    localparam logic [NB_OP-1:0]   OP_SRL    = NB_OP'(8'h02);
    localparam logic [NB_TOUT-1:0] TOUT_LAST = NB_TOUT'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic               rx_done_q;
    logic [NB_TOUT-1:0] tout_cnt;
    logic               rx_evt;
    logic               tout_hit;
    logic [NB_OP-1:0]   op_code;
    logic               op_valid;

    // A level held for several cycles counts as a single byte event.
    assign rx_evt   = i_rx_done & ~rx_done_q;
    assign tout_hit = (tout_cnt == TOUT_LAST);
    assign op_code  = i_rx_byte[NB_OP-1:0];
    assign op_valid = op_code inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                      OP_XOR, OP_NOR, OP_SRA, OP_SRL};

    always_ff @(posedge i_Clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_WAIT_A;
            rx_done_q  <= 1'b0;
            tout_cnt   <= '0;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_op       <= '0;
            o_tx_start <= 1'b0;
            o_tx_byte  <= '0;
            o_busy     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            rx_done_q  <= i_rx_done;
            o_tx_start <= 1'b0;
            case (state)
                S_WAIT_A: begin
                    tout_cnt <= '0;
                    if (rx_evt) begin
                        o_data_a <= i_rx_byte;
                        state    <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    // A byte arriving on the expiry cycle wins over the abort.
                    if (rx_evt) begin
                        o_data_b <= i_rx_byte;
                        tout_cnt <= '0;
                        state    <= S_WAIT_OP;
                    end else if (tout_hit) begin
                        o_error  <= 1'b1;
                        tout_cnt <= '0;
                        state    <= S_WAIT_A;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end
                S_WAIT_OP: begin
                    if (rx_evt) begin
                        tout_cnt <= '0;
                        if (op_valid) begin
                            o_op   <= op_code;
                            o_busy <= 1'b1;
                            state  <= S_EXEC;
                        end else begin
                            o_error <= 1'b1;
                            state   <= S_WAIT_A;
                        end
                    end else if (tout_hit) begin
                        o_error  <= 1'b1;
                        tout_cnt <= '0;
                        state    <= S_WAIT_A;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (rx_evt) o_error <= 1'b1;
                    o_tx_byte  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    state      <= S_TX_START;
                end
                S_TX_START: begin
                    if (rx_evt) o_error <= 1'b1;
                    state <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (rx_evt) o_error <= 1'b1;
                    if (i_tx_done) begin
                        o_busy   <= 1'b0;
                        tout_cnt <= '0;
                        state    <= S_WAIT_A;
                    end
                end
                default: begin
                    o_busy   <= 1'b0;
                    tout_cnt <= '0;
                    state    <= S_WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Randomized self-checking bench for uart_alu_ctrl with a frame-level reference model.
// It uses a behavioural ALU stub and a short timeout.
module tb_uart_alu_ctrl;

    localparam int TOUT = 16;

    logic       i_Clock = 1'b0;
    logic       i_reset_n;
    logic       i_rx_done;
    logic [7:0] i_rx_byte;
    logic       i_tx_done;
    logic [7:0] i_alu_result;
    logic [7:0] o_data_a;
    logic [7:0] o_data_b;
    logic [5:0] o_op;
    logic       o_tx_start;
    logic [7:0] o_tx_byte;
    logic       o_busy;
    logic       o_error;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the controller should be holding.
    logic [7:0] exp_a, exp_b;
    logic [5:0] exp_op;
    logic       exp_err;

    logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    always #5 i_Clock = ~i_Clock;

    uart_alu_ctrl #(
        .NB_DATA        (8),
        .NB_OP          (6),
        .TIMEOUT_CYCLES (TOUT),
        .NB_TOUT        (20)
    ) dut (
        .i_Clock      (i_Clock),
        .i_reset_n    (i_reset_n),
        .i_rx_done    (i_rx_done),
        .i_rx_byte    (i_rx_byte),
        .i_tx_done    (i_tx_done),
        .i_alu_result (i_alu_result),
        .o_data_a     (o_data_a),
        .o_data_b     (o_data_b),
        .o_op         (o_op),
        .o_tx_start   (o_tx_start),
        .o_tx_byte    (o_tx_byte),
        .o_busy       (o_busy),
        .o_error      (o_error)
    );

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return sa >>> b;
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_ref(o_data_a, o_data_b, o_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        i_rx_byte = b;
        i_rx_done = 1'b1;
        repeat (hold) tick();
        i_rx_done = 1'b0;
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_a"},     o_data_a,   0);
        check({tag, "_b"},     o_data_b,   0);
        check({tag, "_op"},    o_op,       0);
        check({tag, "_start"}, o_tx_start, 0);
        check({tag, "_txb"},   o_tx_byte,  0);
        check({tag, "_busy"},  o_busy,     0);
        check({tag, "_err"},   o_error,    0);
    endtask

    task automatic do_reset();
        @(posedge i_Clock);
        #3;
        i_reset_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        tick();
        i_reset_n = 1'b1;
        tick();
        exp_a = 0; exp_b = 0; exp_op = 0; exp_err = 1'b0;
    endtask

    // Sends a full valid frame and follows it up to the TX_WAIT phase.
    task automatic start_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
        int n;
        logic [7:0] exp_tx;
        send_byte(a, 1);
        send_byte(b, 1);
        exp_a = a; exp_b = b; exp_op = opb[5:0];
        exp_tx = alu_ref(a, b, exp_op);
        i_rx_byte = opb;
        i_rx_done = 1'b1;
        n = 1;
        tick();
        i_rx_done = 1'b0;
        n++;
        check("op_reg", o_op, exp_op);
        check("busy_exec", o_busy, 1);
        while (!o_tx_start && n < 10) begin
            tick();
            n++;
        end
        // Opcode cycle, EXEC, then the TX_START cycle carries the pulse.
        check("tx_latency", n, 3);
        check("tx_byte", o_tx_byte, exp_tx);
        check("data_a", o_data_a, exp_a);
        check("data_b", o_data_b, exp_b);
        check("err_frame", o_error, exp_err);
        tick();
        check("tx_start_single", o_tx_start, 0);
        check("busy_wait", o_busy, 1);
    endtask

    task automatic finish_tx(input int waitc);
        logic [7:0] held;
        held = o_tx_byte;
        repeat (waitc) tick();
        check("tx_hold_busy", o_busy, 1);
        check("tx_byte_hold", o_tx_byte, held);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("idle_after_done", o_busy, 0);
    endtask

    initial begin
        logic [7:0] a, b, opb;
        logic [1:0] hi;
        logic [5:0] code;

        i_reset_n = 1'b0;
        i_rx_done = 1'b0;
        i_rx_byte = 8'h00;
        i_tx_done = 1'b0;
        exp_a = 0; exp_b = 0; exp_op = 0; exp_err = 1'b0;
        repeat (2) tick();
        check_outputs_zero("reset");
        i_reset_n = 1'b1;
        tick();

        // Directed ADD frame.
        start_frame(8'h05, 8'h03, 8'h20);
        finish_tx(3);

        // Held rx_done advances exactly one byte.
        send_byte(8'h11, 5);
        check("hold_a", o_data_a, 8'h11);
        check("hold_b_unchanged", o_data_b, exp_b);
        check("hold_not_busy", o_busy, 0);
        send_byte(8'h22, 1);
        exp_a = 8'h11; exp_b = 8'h22;
        check("hold_b_next", o_data_b, 8'h22);
        i_rx_byte = 8'h26; i_rx_done = 1'b1; tick(); i_rx_done = 1'b0;
        tick(); tick();
        check("hold_tx", o_tx_byte, 8'h11 ^ 8'h22);
        finish_tx(0);

        // Randomized valid frames; tx_done pulses outside TX_WAIT must be ignored.
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            hi = 2'($urandom);
            code = valid_ops[$urandom_range(0, 7)];
            opb = {hi, code};
            i_tx_done = 1'b1; tick(); i_tx_done = 1'b0;
            start_frame(a, b, opb);
            finish_tx(int'($urandom_range(0, 4)));
        end
        check("rand_no_err", o_error, 0);

        // Invalid opcode aborts the frame and sets the sticky error.
        send_byte(8'h10, 1);
        send_byte(8'h01, 1);
        i_rx_byte = 8'h3F; i_rx_done = 1'b1; tick(); i_rx_done = 1'b0;
        exp_err = 1'b1;
        begin
            int starts = 0;
            repeat (5) begin
                tick();
                if (o_tx_start) starts++;
            end
            check("inv_no_start", starts, 0);
        end
        check("inv_err", o_error, 1);
        check("inv_op_kept", o_op, exp_op);
        check("inv_idle", o_busy, 0);
        start_frame(8'hF0, 8'h0F, 8'h25);
        check("inv_next_tx", o_tx_byte, 8'hFF);
        finish_tx(1);

        // A byte landing on the expiry cycle is still accepted.
        do_reset();
        send_byte(8'h40, 1);
        repeat (TOUT - 2) tick();
        send_byte(8'h04, 1);
        check("edge_b", o_data_b, 8'h04);
        check("edge_no_err", o_error, 0);
        i_rx_byte = 8'h22; i_rx_done = 1'b1; tick(); i_rx_done = 1'b0;
        tick(); tick();
        check("edge_tx", o_tx_byte, 8'h3C);
        finish_tx(0);

        // Silence after operand A aborts on the TOUT-th cycle.
        send_byte(8'hAA, 1);
        repeat (TOUT - 2) tick();
        check("tout_not_yet", o_error, 0);
        tick();
        exp_err = 1'b1;
        check("tout_err", o_error, 1);
        check("tout_keep_a", o_data_a, 8'hAA);
        repeat (4) tick();
        start_frame(8'h01, 8'h02, 8'h22);
        check("tout_sub", o_tx_byte, 8'hFF);
        finish_tx(0);

        // A byte arriving while transmitting is dropped but flagged.
        do_reset();
        start_frame(8'h30, 8'h03, 8'h02);
        send_byte(8'h77, 1);
        exp_err = 1'b1;
        check("busy_err", o_error, 1);
        check("busy_txb", o_tx_byte, 8'h06);
        check("busy_a", o_data_a, 8'h30);
        finish_tx(1);
        start_frame(8'h81, 8'h01, 8'h03);
        finish_tx(0);

        // Asynchronous reset while waiting for transmit completion.
        start_frame(8'h09, 8'h07, 8'h24);
        do_reset();
        check("post_rst_idle", o_busy, 0);
        start_frame(8'h0C, 8'h0A, 8'h27);
        finish_tx(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
